// File: rtl/select_encode_multi.sv
// Register select/encode unit: one-hot Rin/Rout enables, sign-extended C constant and a
// load/store-multiple sequencer. Optional macro SELECT_ENCODE_BA_ZERO_EN makes BAout on R0 read as 0.
module select_encode_multi #(
   parameter int NUM_REGS = 16,
   parameter int SEL_W    = 4,
   parameter int IR_W     = 32,
   parameter int RA_LSB   = 23,
   parameter int RB_LSB   = 19,
   parameter int RC_LSB   = 15,
   parameter int C_W      = 19
) (
   input  logic                clock,
   input  logic                reset,
   input  logic [IR_W-1:0]     ir_in,
   input  logic                ir_load,
   input  logic                Rin,
   input  logic                Rout,
   input  logic                BAout,
   input  logic                GRA,
   input  logic                GRB,
   input  logic                GRC,
   input  logic                multi_start,
   input  logic                multi_store,
   input  logic                step,
   output logic [NUM_REGS-1:0] rin_out,
   output logic [NUM_REGS-1:0] rout_out,
   output logic [IR_W-1:0]     c_sign_extended,
   output logic [SEL_W-1:0]    cur_reg,
   output logic                busy,
   output logic                multi_done,
   output logic [SEL_W:0]      xfer_count,
   output logic                sel_error
);

   typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;

   state_t              state;
   logic [IR_W-1:0]     ir_q;
   logic [NUM_REGS-1:0] mask_q;
   logic [NUM_REGS-1:0] next_mask;
   logic                dir_q;
   logic [SEL_W-1:0]    ra, rb, rc, sel, xfer_reg;
   logic                read_en;
   logic                unused_ir_bits;

   function automatic logic [NUM_REGS-1:0] onehot(input logic [SEL_W-1:0] idx);
      onehot      = '0;
      onehot[idx] = 1'b1;
   endfunction

   function automatic logic [SEL_W-1:0] lowest_set(input logic [NUM_REGS-1:0] m);
      lowest_set = '0;
      for (int i = NUM_REGS - 1; i >= 0; i--)
         if (m[i]) lowest_set = SEL_W'(i);
   endfunction

   assign ra        = ir_q[RA_LSB +: SEL_W];
   assign rb        = ir_q[RB_LSB +: SEL_W];
   assign rc        = ir_q[RC_LSB +: SEL_W];
   assign sel       = GRA ? ra : (GRB ? rb : (GRC ? rc : '0));
   assign xfer_reg  = lowest_set(mask_q);
   // Clearing the lowest set bit retires the register just transferred.
   assign next_mask = mask_q & (mask_q - NUM_REGS'(1));

   assign c_sign_extended = {{(IR_W - C_W){ir_q[C_W-1]}}, ir_q[C_W-1:0]};
   assign unused_ir_bits  = ^ir_q;

   always_ff @(posedge clock) begin
      if (reset) begin
         ir_q       <= '0;
         state      <= IDLE;
         mask_q     <= '0;
         dir_q      <= 1'b0;
         xfer_count <= '0;
         busy       <= 1'b0;
         multi_done <= 1'b0;
      end else begin
         // The mask is taken from the old ir_q even when a new IR is latched at the same edge.
         if (ir_load && state == IDLE)
            ir_q <= ir_in;
         case (state)
            IDLE: begin
               multi_done <= 1'b0;
               if (multi_start) begin
                  mask_q     <= ir_q[NUM_REGS-1:0];
                  dir_q      <= multi_store;
                  xfer_count <= '0;
                  busy       <= 1'b1;
                  if (|ir_q[NUM_REGS-1:0]) begin
                     state <= XFER;
                  end else begin
                     state      <= DONE;
                     multi_done <= 1'b1;
                  end
               end
            end
            XFER: begin
               if (step) begin
                  mask_q     <= next_mask;
                  xfer_count <= xfer_count + (SEL_W+1)'(1);
                  if (next_mask == '0) begin
                     state      <= DONE;
                     multi_done <= 1'b1;
                  end
               end
            end
            DONE: begin
               state      <= IDLE;
               busy       <= 1'b0;
               multi_done <= 1'b0;
            end
            default: begin
               state      <= IDLE;
               busy       <= 1'b0;
               multi_done <= 1'b0;
            end
         endcase
      end
   end

   always_comb begin
      cur_reg   = '0;
      rin_out   = '0;
      rout_out  = '0;
      sel_error = 1'b0;
      read_en   = 1'b0;
      case (state)
         IDLE: begin
            cur_reg   = sel;
            sel_error = (GRA & GRB) | (GRA & GRC) | (GRB & GRC);
            read_en   = Rout | BAout;
`ifdef SELECT_ENCODE_BA_ZERO_EN
            if (BAout && sel == '0)
               read_en = 1'b0;
`else
            read_en = Rout | BAout;
`endif
            if (Rin)     rin_out  = onehot(sel);
            if (read_en) rout_out = onehot(sel);
         end
         XFER: begin
            cur_reg = xfer_reg;
            if (dir_q) rout_out = onehot(xfer_reg);
            else       rin_out  = onehot(xfer_reg);
         end
         default: begin
            cur_reg = '0;
         end
      endcase
   end

endmodule

// File: doc/select_encode_multi.md
Name: select_encode_multi

Overview:
- Parametrised register select/encode unit for the datapath register file; successor of the single-shot GRA/GRB/GRC decoder.
- Holds its own IR copy and produces one-hot Rin/Rout enables plus the sign-extended C constant.
- Adds a multi-register sequencer: walks a register bitmask from IR for load-multiple/store-multiple, one register per step handshake.
- Sits between the control unit and the register-file enable inputs.

Parameters:
- NUM_REGS, 16, number of registers; must be a power of 2, minimum 2.
- SEL_W, 4, register field width; equals log2(NUM_REGS).
- IR_W, 32, instruction width.
- RA_LSB, 23, LSB of Ra field in IR.
- RB_LSB, 19, LSB of Rb field.
- RC_LSB, 15, LSB of Rc field.
- C_W, 19, constant field width IR[C_W-1:0], including sign bit.

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- ir_in  in  IR_W  instruction word
- ir_load  in  1  latch ir_in into ir_q
- Rin  in  1  single-mode write enable request
- Rout  in  1  single-mode read enable request
- BAout  in  1  base-address read request
- GRA, GRB, GRC  in  1 each  field select
- multi_start  in  1  begin multi-register sequence
- multi_store  in  1  sampled with multi_start: 1 = store (drives Rout), 0 = load (drives Rin)
- step  in  1  current register transfer complete
- rin_out  out  NUM_REGS  one-hot write enables
- rout_out  out  NUM_REGS  one-hot read enables
- c_sign_extended  out  IR_W  sign-extended constant
- cur_reg  out  SEL_W  register index being driven
- busy  out  1  sequencer active
- multi_done  out  1  one-cycle completion pulse
- xfer_count  out  SEL_W+1  transfers completed in the last or current sequence
- sel_error  out  1  more than one of GRA/GRB/GRC asserted

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset: ir_q=0, state=IDLE, mask_q=0, dir_q=0, xfer_count=0, busy=0, multi_done=0, sel_error=0. With Rin/Rout/BAout low, rin_out=rout_out=0, cur_reg=0, c_sign_extended=0.
- Reset takes priority over every other input, including mid-sequence: the cycle after reset is asserted, state returns to IDLE and all enables drop to 0.
- IR latch: ir_load at edge n sets ir_q=ir_in; fields are valid from cycle n+1. ir_load is ignored while busy=1.
- c_sign_extended = {(IR_W-C_W) copies of ir_q[C_W-1], ir_q[C_W-1:0]}. Combinational from ir_q; valid in all states.
- Single mode (state IDLE), outputs combinational:
  - Field select priority is GRA > GRB > GRC. sel = the highest-priority selected field; sel = 0 if none is asserted.
  - cur_reg = sel.
  - rin_out = onehot(sel) & Rin.
  - rout_out = onehot(sel) & (Rout|BAout).
  - sel_error = two or more of GRA/GRB/GRC high.
- Multi mode FSM: states IDLE, XFER, DONE.
  - IDLE, multi_start=1: mask_q = ir_q[NUM_REGS-1:0], dir_q = multi_store, xfer_count = 0. Next state is XFER if mask is nonzero, DONE if mask is zero.
  - XFER:
    - cur_reg = index of lowest set bit of mask_q.
    - dir_q=1: rout_out = onehot(cur_reg), rin_out = 0. dir_q=0: rin_out = onehot(cur_reg), rout_out = 0.
    - Rin, Rout, BAout and GR* are ignored; sel_error = 0.
    - Enables hold steady until step.
    - On step: clear that mask bit and increment xfer_count. If the remaining mask is 0, go to DONE; otherwise stay in XFER and select the next-lowest register on the following cycle.
  - DONE: multi_done=1 for exactly one cycle, rin_out=rout_out=0, then return to IDLE. xfer_count holds until the next multi_start or reset.
  - busy=1 in XFER and DONE.
  - multi_start while busy is ignored. step in IDLE or DONE is ignored.
  - Simultaneous ir_load and multi_start in IDLE: the mask is taken from the old ir_q, and the new IR is latched at the same edge.
- Full mask (all NUM_REGS bits set) takes exactly NUM_REGS steps; xfer_count reaches NUM_REGS without overflow.

Optional Feature:
- SELECT_ENCODE_BA_ZERO_EN defined: in single mode, when BAout=1 and sel=0, rout_out = all zeros, so R0 reads as constant 0 for base addressing. Rout=1 with sel=0 still enables rout_out[0].
- Undefined: BAout is treated identically to Rout in all cases.

Test Plan:
- Reset mid-XFER (mask 0x00F0, after 1 step) -> next cycle busy=0, rin_out=rout_out=0, xfer_count=0, ir_q=0.
- Single mode: load IR=0x03880000 (Ra=7, Rb=1), GRA=1, GRB=1, Rin=1 -> rin_out=0x0080, sel_error=1. IR=0x0007FFFF -> c_sign_extended=0xFFFFFFFF; IR=0x0003FFFF -> 0x0003FFFF.
- Store-multiple, IR[15:0]=0x8005, multi_store=1, step asserted every 2nd cycle -> rout_out sequence 0x0001, 0x0004, 0x8000, each held until step; multi_done pulses once; xfer_count=3; rin_out=0 throughout.
- Load-multiple with mask 0x0000 -> DONE the next cycle, multi_done=1 for one cycle, no enables asserted, xfer_count=0.
- Full mask 0xFFFF with step held high -> 16 consecutive one-hot rin_out values 0x0001..0x8000, xfer_count=16; multi_start and ir_load asserted during the sequence are ignored.
- BAout=1, Ra=0, GRA=1 -> rout_out=0x0000 with SELECT_ENCODE_BA_ZERO_EN defined, 0x0001 without; Ra=5 -> 0x0020 in both builds.
